// File: rtl/sd_dac_tx.sv
// Generic sample FIFO: power-of-two depth, occupancy counter, combinational head read.
// Latency: a pushed entry is visible at the head one clock after the push edge (no bypass).
// Backpressure: push_rdy drops while full; pop must only be requested while non-empty.
module sd_dac_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    input  logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;

    assign push_rdy = (count != FULL_CNT);
    assign push     = push_vld && push_rdy;
    assign empty    = (count == '0);
    assign pop_dat  = mem[rd_ptr];
    assign level    = count;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; simultaneous push+pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop_vld})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// First-order sigma-delta 1-bit DAC: plays each queued sample for SAMPLE_DIV clocks on pdm_out.
// Latency: sample pushed in cycle T loads at edge T+1, first pdm bit is driven after edge T+2.
// Backpressure: s_ready = !fifo_full; an empty FIFO at a sample boundary repeats the last sample.
module sd_dac_tx #(
    parameter int DATA_BITS  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          pdm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          busy
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   acc;
    logic [DATA_BITS-1:0]   cur;
    logic [DIV_W-1:0]       div;
    logic [DATA_BITS:0]     sum;
    logic                   boundary;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_dat;

    sd_dac_fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (s_valid),
        .push_dat (s_data),
        .push_rdy (s_ready),
        .pop_vld  (fifo_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .level    (fill_level)
    );

    // Carry out of the accumulator is the next pulse-density bit.
    assign sum      = {1'b0, acc} + {1'b0, cur};
    assign boundary = (state == RUN) && (div == DIV_LAST);
    // Loads happen on leaving IDLE or at a sample boundary; a falling enable suppresses both.
    assign fifo_pop = enable && !fifo_empty && ((state == IDLE) || boundary);

    // Modulator FSM: IDLE holds everything at zero, RUN integrates cur and steps the sample divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cur      <= '0;
            div      <= '0;
            pdm_out  <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    acc     <= '0;
                    div     <= '0;
                    pdm_out <= 1'b0;
                    if (enable && !fifo_empty) begin
                        cur   <= fifo_dat;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        acc     <= '0;
                        cur     <= '0;
                        div     <= '0;
                        pdm_out <= 1'b0;
                    end else begin
                        // acc keeps its residue across boundaries so long-term density stays exact.
                        acc     <= sum[DATA_BITS-1:0];
                        pdm_out <= sum[DATA_BITS];
                        if (boundary) begin
                            div <= '0;
                            if (!fifo_empty) begin
                                cur <= fifo_dat;
                            end else begin
                                underrun <= 1'b1;
                            end
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dac_tx.sv
// Bench for sd_dac_tx: directed scenarios plus a random phase against a reference model.
// The model predicts each pdm bit from the running sum of played sample values:
// bit k = floor(S_k / 2^DATA_BITS) - floor(S_(k-1) / 2^DATA_BITS).
module tb_sd_dac_tx;
    localparam int DB    = 16;
    localparam int DEPTH = 4;
    localparam int SD    = 1024;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [DB-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          pdm_out;
    logic          underrun;
    logic [2:0]    fill_level;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned       q[$];
    bit                m_run;
    bit                m_pdm;
    bit                m_und;
    int                m_pos;
    int unsigned       m_cur;
    longint unsigned   m_sum;
    int                win_ones;
    int                last_win_ones;
    int                und_cnt;
    bit                win_ok;

    sd_dac_tx #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH),
        .SAMPLE_DIV (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pdm_out    (pdm_out),
        .underrun   (underrun),
        .fill_level (fill_level),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run    = 1'b0;
        m_pdm    = 1'b0;
        m_und    = 1'b0;
        m_pos    = 0;
        m_cur    = 0;
        m_sum    = 0;
        win_ok   = 1'b0;
        win_ones = 0;
    endtask

    // One clock: drive inputs, advance the model by one edge, then compare all outputs.
    task automatic cyc(input bit en, input bit sv, input logic [DB-1:0] sd);
        bit              push;
        bit              played;
        bit              wrap;
        int unsigned     used;
        longint unsigned prev;
        longint unsigned tot;
        longint unsigned lo;
        longint unsigned hi;
        enable  = en;
        s_valid = sv;
        s_data  = sd;
        push    = sv && (q.size() < DEPTH);
        played  = 1'b0;
        wrap    = 1'b0;
        used    = 0;
        @(posedge clk);
        m_und = 1'b0;
        if (!m_run) begin
            m_pdm = 1'b0;
            if (en && q.size() != 0) begin
                m_cur    = q.pop_front();
                m_run    = 1'b1;
                m_pos    = 0;
                m_sum    = 0;
                win_ones = 0;
                win_ok   = 1'b1;
            end
        end else if (!en) begin
            m_run  = 1'b0;
            m_pdm  = 1'b0;
            win_ok = 1'b0;
        end else begin
            used   = m_cur;
            played = 1'b1;
            prev   = m_sum;
            m_sum  = m_sum + m_cur;
            m_pdm  = bit'((m_sum >> DB) - (prev >> DB));
            m_pos++;
            if (m_pos == SD) begin
                m_pos = 0;
                wrap  = 1'b1;
                if (q.size() != 0) m_cur = q.pop_front();
                else m_und = 1'b1;
            end
        end
        if (push) q.push_back(sd);
        #1;
        chk("pdm_out", pdm_out, m_pdm);
        chk("busy", busy, m_run);
        chk("underrun", underrun, m_und);
        chk("fill_level", fill_level, q.size());
        chk("s_ready", s_ready, q.size() < DEPTH);
        und_cnt += underrun;
        if (played) win_ones += pdm_out;
        if (wrap) begin
            if (win_ok) begin
                tot = longint'(SD) * used;
                lo  = tot >> DB;
                hi  = lo + (((tot % (64'd1 << DB)) != 0) ? 1 : 0);
                chk("window_density", (win_ones == lo) || (win_ones == hi), 1);
                last_win_ones = win_ones;
            end
            win_ones = 0;
            win_ok   = 1'b1;
        end
    endtask

    // Asserts reset between clock edges and checks the outputs clear without a clock.
    task automatic async_reset();
        enable  = 1'b0;
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pdm_out", pdm_out, 0);
        chk("rst_fill_level", fill_level, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DB-1:0] v [5];
        int f;
        rst_n   = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        und_cnt = 0;
        last_win_ones = -1;
        model_reset();

        // Reset state
        async_reset();

        // 1: half-scale sample, 0,1,0,1 pattern, 512 ones per window, underrun each boundary
        cyc(1, 1, 16'h8000);
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        chk("t1_first_bit", pdm_out, 0);
        cyc(1, 0, '0);
        chk("t1_second_bit", pdm_out, 1);
        und_cnt = 0;
        repeat (3 * SD - 2) cyc(1, 0, '0);
        chk("t1_window_ones", last_win_ones, 512);
        chk("t1_underruns", und_cnt, 3);

        // 2: full-scale then zero sample
        async_reset();
        cyc(1, 1, 16'hFFFF);
        cyc(1, 1, 16'h0000);
        cyc(1, 0, '0);
        chk("t2_first_bit", pdm_out, 0);
        repeat (SD - 1) cyc(1, 0, '0);
        chk("t2_ffff_ones", last_win_ones, 1023);
        repeat (SD) cyc(1, 0, '0);
        chk("t2_zero_residue", last_win_ones <= 1, 1);

        // 3: fill FIFO while disabled, fifth sample held, then drain one per window
        async_reset();
        for (int i = 0; i < 5; i++) v[i] = DB'($urandom);
        for (int i = 0; i < 4; i++) cyc(0, 1, v[i]);
        chk("t3_full_ready", s_ready, 0);
        chk("t3_fill4", fill_level, 4);
        cyc(0, 1, v[4]);
        chk("t3_held_fill", fill_level, 4);
        cyc(1, 1, v[4]);
        cyc(1, 1, v[4]);
        chk("t3_fifth_accepted", fill_level, 4);
        repeat (SD - 1) cyc(1, 0, '0);
        chk("t3_fill_w1", fill_level, 3);
        repeat (SD) cyc(1, 0, '0);
        chk("t3_fill_w2", fill_level, 2);

        // 4: push exactly on the boundary cycle with one entry queued
        repeat (SD) cyc(1, 0, '0);
        chk("t4_pre_fill", fill_level, 1);
        for (int i = 0; i < SD && m_pos != SD - 1; i++) cyc(1, 0, '0);
        cyc(1, 1, DB'($urandom));
        chk("t4_fill", fill_level, 1);
        chk("t4_no_underrun", underrun, 0);

        // 5: drop enable mid-sample, then resume from the next queued sample
        repeat (SD / 2) cyc(1, 0, '0);
        f = int'(fill_level);
        cyc(0, 0, '0);
        chk("t5_pdm_low", pdm_out, 0);
        chk("t5_busy_low", busy, 0);
        chk("t5_fill_kept", fill_level, f);
        repeat (5) cyc(0, 0, '0);
        cyc(1, 0, '0);
        chk("t5_resume_fill", fill_level, f - 1);
        chk("t5_resume_busy", busy, 1);
        repeat (SD) cyc(1, 0, '0);

        // 6: async reset while running with three samples queued
        repeat (3) cyc(1, 1, 16'hFFFF);
        chk("t6_pre_fill", fill_level, 3);
        repeat (4) cyc(1, 0, '0);
        async_reset();

        // Random traffic against the model
        for (int i = 0; i < 8000; i++) begin
            cyc($urandom_range(0, 2999) != 0, $urandom_range(0, 299) == 0, DB'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
